msrv32_wb_mux_sel_unit: RTL and testbench
=========================================

MSRV32_WB_MUX_SEL_UNIT -- requirements
Module: msrv32_wb_mux_sel_unit

Interface
REQ-001 Parameter: XLEN, default 32, data-path width of every data port.
REQ-002 Clocking: the block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 ms_riscv32_mp_clk_in  input  1  clock; registered outputs update on its rising edge.
REQ-004 ms_riscv32_mp_rst_n_in  input  1  asynchronous active-low reset.
REQ-005 wb_mux_sel_reg_in  input  3  write-back source select.
REQ-006 alu_result_in  input  XLEN  ALU result.
REQ-007 lu_output_in  input  XLEN  load-unit output.
REQ-008 imm_reg_in  input  XLEN  registered immediate.
REQ-009 iadder_out_reg_in  input  XLEN  registered immediate-adder result.
REQ-010 csr_data_in  input  XLEN  CSR read data.
REQ-011 pc_plus_4_reg_in  input  XLEN  registered PC+4.
REQ-012 rs2_reg_in  input  XLEN  registered rs2 operand.
REQ-013 alu_source_reg_in  input  1  ALU 2nd-operand select.
REQ-014 wb_mux_out  output  XLEN  combinational write-back data.
REQ-015 alu_2nd_src_mux_out  output  XLEN  combinational ALU 2nd operand.
REQ-016 wb_sel_illegal_out  output  1  combinational flag: select code unused.
REQ-017 wb_mux_out_q  output  XLEN  wb_mux_out registered one cycle.
REQ-018 wb_sel_illegal_q  output  1  wb_sel_illegal_out registered one cycle.

Function
REQ-019 wb_mux_out SHALL be purely combinational, zero-cycle latency, from wb_mux_sel_reg_in: 000 alu_result_in; 001 lu_output_in; 010 imm_reg_in; 011 iadder_out_reg_in; 100 csr_data_in; 101 pc_plus_4_reg_in.
REQ-020 Select codes 110 and 111 SHALL drive wb_mux_out to all zeros and assert wb_sel_illegal_out; codes 000-101 SHALL deassert it.
REQ-021 alu_2nd_src_mux_out SHALL be combinational: alu_source_reg_in=0 selects imm_reg_in; 1 selects rs2_reg_in.
REQ-022 alu_2nd_src_mux_out SHALL be independent of wb_mux_sel_reg_in; wb_mux_out SHALL be independent of alu_source_reg_in.
REQ-023 Combinational outputs SHALL settle in the same delta cycle as any input change; no clock or reset dependency.
REQ-024 On every rising clock edge with reset deasserted, wb_mux_out_q <= wb_mux_out and wb_sel_illegal_q <= wb_sel_illegal_out (latency exactly 1 cycle, no enable).
REQ-025 Unknown (X/Z) select bits SHALL be treated as illegal: wb_mux_out all zeros, wb_sel_illegal_out = 1 (synthesis: default branch).
REQ-026 No arithmetic; data SHALL pass bit-exact, no extension or truncation.

Reset
REQ-027 While ms_riscv32_mp_rst_n_in=0, wb_mux_out_q SHALL be 0 and wb_sel_illegal_q SHALL be 0, asserted immediately (asynchronous) without a clock edge.
REQ-028 Reset SHALL NOT affect combinational outputs wb_mux_out, alu_2nd_src_mux_out, wb_sel_illegal_out.
REQ-029 Reset deassertion SHALL be honoured at the next rising edge; first captured value is that edge's wb_mux_out.
REQ-030 Reset asserted mid-operation SHALL clear registered outputs within the same timestep regardless of clock state.

Verification
REQ-031 sel=000, alu=0x3, imm=0x1, alu_src=0 -> wb_mux_out=0x3, alu_2nd_src_mux_out=0x1, illegal=0, with no clock edge.
REQ-032 sel=001, lu=0x7, imm=0x8, alu_src=0 -> wb_mux_out=0x7, alu_2nd_src_mux_out=0x8.
REQ-033 Sweep sel 010..101 with imm=0x8, iadder=0x9, csr=0xA, pc4=0xB -> wb_mux_out 0x8, 0x9, 0xA, 0xB; alu_src=1, rs2=0xC -> alu_2nd_src_mux_out=0xC.
REQ-034 sel=110 and 111 with all inputs 0xFFFFFFFF -> wb_mux_out=0x0, wb_sel_illegal_out=1; after one edge wb_sel_illegal_q=1.
REQ-035 sel=000, alu=0xDEADBEEF, clock one edge -> wb_mux_out_q=0xDEADBEEF; then drop rst_n between edges -> wb_mux_out_q=0 immediately while wb_mux_out stays 0xDEADBEEF.
REQ-036 Change alu_result_in between edges -> wb_mux_out follows at once; wb_mux_out_q changes only at the next rising edge.

Source files
------------

// File: rtl/msrv32_wb_mux_sel_unit.sv
// ----------------------------------------------------------------------------
// msrv32_wb_mux_sel_unit
// Write-back source selector and ALU second-operand selector for the msrv32
// core. Both selectors are combinational. A one-cycle registered copy of the
// write-back data and its illegal-select flag is also provided.
//
// Ports:
//   ms_riscv32_mp_clk_in    in   1     clock, registered outputs on rising edge
//   ms_riscv32_mp_rst_n_in  in   1     asynchronous active-low reset
//   wb_mux_sel_reg_in       in   3     write-back source select
//   alu_result_in           in   XLEN  ALU result
//   lu_output_in            in   XLEN  load-unit output
//   imm_reg_in              in   XLEN  registered immediate
//   iadder_out_reg_in       in   XLEN  registered immediate-adder result
//   csr_data_in             in   XLEN  CSR read data
//   pc_plus_4_reg_in        in   XLEN  registered PC+4
//   rs2_reg_in              in   XLEN  registered rs2 operand
//   alu_source_reg_in       in   1     ALU 2nd operand select (0 imm, 1 rs2)
//   wb_mux_out              out  XLEN  combinational write-back data
//   alu_2nd_src_mux_out     out  XLEN  combinational ALU 2nd operand
//   wb_sel_illegal_out      out  1     combinational unused-select flag
//   wb_mux_out_q            out  XLEN  wb_mux_out delayed one cycle
//   wb_sel_illegal_q        out  1     wb_sel_illegal_out delayed one cycle
// ----------------------------------------------------------------------------
module msrv32_wb_mux_sel_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_n_in,
    input  logic [2:0]      wb_mux_sel_reg_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] lu_output_in,
    input  logic [XLEN-1:0] imm_reg_in,
    input  logic [XLEN-1:0] iadder_out_reg_in,
    input  logic [XLEN-1:0] csr_data_in,
    input  logic [XLEN-1:0] pc_plus_4_reg_in,
    input  logic [XLEN-1:0] rs2_reg_in,
    input  logic            alu_source_reg_in,
    output logic [XLEN-1:0] wb_mux_out,
    output logic [XLEN-1:0] alu_2nd_src_mux_out,
    output logic            wb_sel_illegal_out,
    output logic [XLEN-1:0] wb_mux_out_q,
    output logic            wb_sel_illegal_q
);

    localparam logic [2:0] SEL_ALU    = 3'b000;
    localparam logic [2:0] SEL_LU     = 3'b001;
    localparam logic [2:0] SEL_IMM    = 3'b010;
    localparam logic [2:0] SEL_IADDER = 3'b011;
    localparam logic [2:0] SEL_CSR    = 3'b100;
    localparam logic [2:0] SEL_PC4    = 3'b101;

    logic [XLEN-1:0] wb_mux_d;
    logic            wb_sel_illegal_d;

    // Write-back source select; unused or unknown codes fall to the default
    // branch and produce zero data with the illegal flag set.
    always_comb begin
        wb_mux_d         = '0;
        wb_sel_illegal_d = 1'b0;
        case (wb_mux_sel_reg_in)
            SEL_ALU:    wb_mux_d = alu_result_in;
            SEL_LU:     wb_mux_d = lu_output_in;
            SEL_IMM:    wb_mux_d = imm_reg_in;
            SEL_IADDER: wb_mux_d = iadder_out_reg_in;
            SEL_CSR:    wb_mux_d = csr_data_in;
            SEL_PC4:    wb_mux_d = pc_plus_4_reg_in;
            default: begin
                wb_mux_d         = '0;
                wb_sel_illegal_d = 1'b1;
            end
        endcase
    end

    assign wb_mux_out         = wb_mux_d;
    assign wb_sel_illegal_out = wb_sel_illegal_d;

    // ALU second operand: immediate or rs2.
    assign alu_2nd_src_mux_out = alu_source_reg_in ? rs2_reg_in : imm_reg_in;

    // One-cycle registered copy of the write-back result.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            wb_mux_out_q     <= '0;
            wb_sel_illegal_q <= 1'b0;
        end else begin
            wb_mux_out_q     <= wb_mux_d;
            wb_sel_illegal_q <= wb_sel_illegal_d;
        end
    end

endmodule

// File: tb/tb_msrv32_wb_mux_sel_unit.sv
// ----------------------------------------------------------------------------
// tb_msrv32_wb_mux_sel_unit
// Directed stimulus pushes hand-computed expectations into a scoreboard queue
// and strobes an event; a separate monitor pops and compares all outputs.
// ----------------------------------------------------------------------------
module tb_msrv32_wb_mux_sel_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sel;
    logic [31:0] alu, lu, imm, iadder, csr, pc4, rs2;
    logic        src;
    logic [31:0] wb, alu2, wbq;
    logic        ill, illq;

    msrv32_wb_mux_sel_unit #(.XLEN(32)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .wb_mux_sel_reg_in      (sel),
        .alu_result_in          (alu),
        .lu_output_in           (lu),
        .imm_reg_in             (imm),
        .iadder_out_reg_in      (iadder),
        .csr_data_in            (csr),
        .pc_plus_4_reg_in       (pc4),
        .rs2_reg_in             (rs2),
        .alu_source_reg_in      (src),
        .wb_mux_out             (wb),
        .alu_2nd_src_mux_out    (alu2),
        .wb_sel_illegal_out     (ill),
        .wb_mux_out_q           (wbq),
        .wb_sel_illegal_q       (illq)
    );

    typedef struct {
        string       name;
        logic [31:0] wb;
        logic [31:0] alu2;
        logic        ill;
        logic [31:0] wbq;
        logic        illq;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   vectors     = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on each strobe, pop the oldest expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                if (wb !== e.wb || alu2 !== e.alu2 || ill !== e.ill ||
                    wbq !== e.wbq || illq !== e.illq) begin
                    miscompares++;
                    $display("FAIL %s: actual wb=%h alu2=%h ill=%b wbq=%h illq=%b required wb=%h alu2=%h ill=%b wbq=%h illq=%b",
                             e.name, wb, alu2, ill, wbq, illq,
                             e.wb, e.alu2, e.ill, e.wbq, e.illq);
                end
            end
        end
    end

    // Settle, queue the expectation, strobe the monitor, hold inputs a step.
    task automatic expect_out(input string name, input logic [31:0] e_wb,
                              input logic [31:0] e_alu2, input logic e_ill,
                              input logic [31:0] e_wbq, input logic e_illq);
        exp_t e;
        #1;
        e.name = name; e.wb = e_wb; e.alu2 = e_alu2; e.ill = e_ill;
        e.wbq = e_wbq; e.illq = e_illq;
        sb.push_back(e);
        -> sample_ev;
        #1;
    endtask

    logic [31:0] exp_wb_tbl   [8];
    logic [31:0] exp_alu2_tbl [8];

    initial begin
        exp_wb_tbl   = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                         32'h5555_5555, 32'h6666_6666, 32'h0000_0000, 32'h0000_0000};
        exp_alu2_tbl = '{32'h3333_3333, 32'h7777_7777, 32'h3333_3333, 32'h7777_7777,
                         32'h3333_3333, 32'h7777_7777, 32'h3333_3333, 32'h7777_7777};

        rst_n = 1'b0; sel = 3'b000; src = 1'b0;
        alu = '0; lu = '0; imm = '0; iadder = '0; csr = '0; pc4 = '0; rs2 = '0;
        expect_out("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Combinational paths checked while held in reset.
        alu = 32'h3; imm = 32'h1; sel = 3'b000; src = 1'b0;
        expect_out("sel000", 32'h3, 32'h1, 1'b0, 32'h0, 1'b0);
        lu = 32'h7; imm = 32'h8; sel = 3'b001;
        expect_out("sel001", 32'h7, 32'h8, 1'b0, 32'h0, 1'b0);
        iadder = 32'h9; csr = 32'hA; pc4 = 32'hB; rs2 = 32'hC;
        sel = 3'b010;
        expect_out("sel010", 32'h8, 32'h8, 1'b0, 32'h0, 1'b0);
        sel = 3'b011; src = 1'b1;
        expect_out("sel011", 32'h9, 32'hC, 1'b0, 32'h0, 1'b0);
        sel = 3'b100;
        expect_out("sel100", 32'hA, 32'hC, 1'b0, 32'h0, 1'b0);
        sel = 3'b101;
        expect_out("sel101", 32'hB, 32'hC, 1'b0, 32'h0, 1'b0);
        src = 1'b0;
        expect_out("src_indep", 32'hB, 32'h8, 1'b0, 32'h0, 1'b0);

        alu = '1; lu = '1; imm = '1; iadder = '1; csr = '1; pc4 = '1; rs2 = '1;
        src = 1'b1; sel = 3'b110;
        expect_out("sel110", 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
        sel = 3'b111;
        expect_out("sel111", 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);

        // Release reset and capture the illegal flag.
        @(negedge clk);
        rst_n = 1'b1;
        expect_out("illegal_pre_edge", 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
        @(posedge clk);
        expect_out("illegal_q", 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);

        @(negedge clk);
        sel = 3'b000; alu = 32'hDEAD_BEEF;
        expect_out("deadbeef_comb", 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        expect_out("deadbeef_q", 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Data change between edges: comb follows, register waits.
        alu = 32'h1234_5678;
        expect_out("mid_change_comb", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        expect_out("mid_change_q", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 1'b0);

        // Asynchronous reset between edges.
        alu = 32'hDEAD_BEEF;
        @(posedge clk);
        expect_out("pre_async_rst", 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        rst_n = 1'b0;
        expect_out("async_rst", 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);

        // Deassertion: first captured value is the next edge's wb_mux_out.
        @(negedge clk);
        sel = 3'b010; imm = 32'h55; rst_n = 1'b1;
        expect_out("deassert_pre", 32'h55, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        expect_out("first_capture", 32'h55, 32'hFFFF_FFFF, 1'b0, 32'h55, 1'b0);

        // Clocked sweep of every select code with distinct source patterns.
        alu = 32'h1111_1111; lu = 32'h2222_2222; imm = 32'h3333_3333;
        iadder = 32'h4444_4444; csr = 32'h5555_5555; pc4 = 32'h6666_6666;
        rs2 = 32'h7777_7777;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sel = 3'(i);
            src = (i % 2) == 1;
            @(posedge clk);
            expect_out($sformatf("sweep%0d", i), exp_wb_tbl[i], exp_alu2_tbl[i],
                       i >= 6, exp_wb_tbl[i], i >= 6);
        end

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && sb.size() != 0; k++) #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: actual %0d entries pending, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
